cam_cfg_sequencer: RTL and testbench

CAM_CFG_SEQUENCER -- requirements
Module: cam_cfg_sequencer

---
 rtl/cam_cfg_pkg.sv | 70 +++++++
 rtl/cfg_delay_timer.sv | 26 ++
 rtl/cam_cfg_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_cam_cfg_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera register-table sequencer:
// FSM state encoding, table entry layout and command-byte helpers.
package cam_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_DEV,
    ST_AH,
    ST_AL,
    ST_DAT,
    ST_WAIT,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } cfg_state_e;

  // A register address of all ones marks a millisecond pause entry.
  localparam logic [15:0] DELAY_MARKER = 16'hFFFF;

  localparam int ENTRY_W       = 24;
  localparam int ENTRY_ADDR_HI = 23;
  localparam int ENTRY_ADDR_LO = 8;
  localparam int ENTRY_VAL_HI  = 7;
  localparam int ENTRY_VAL_LO  = 0;

  localparam logic [1:0] SEL_DEV = 2'd0;
  localparam logic [1:0] SEL_AH  = 2'd1;
  localparam logic [1:0] SEL_AL  = 2'd2;
  localparam logic [1:0] SEL_DAT = 2'd3;

  // Command word layout: {start, stop, byte}.
  function automatic logic [9:0] cfg_cmd(input logic [1:0] sel,
                                         input logic [6:0] dev,
                                         input logic [15:0] reg_addr,
                                         input logic [7:0] value);
    logic [9:0] c;
    c = '0;
    case (sel)
      SEL_DEV: c = {1'b1, 1'b0, dev, 1'b0};
      SEL_AH:  c = {1'b0, 1'b0, reg_addr[15:8]};
      SEL_AL:  c = {1'b0, 1'b0, reg_addr[7:0]};
      default: c = {1'b0, 1'b1, value};
    endcase
    return c;
  endfunction

  function automatic cfg_state_e byte_state(input logic [1:0] sel);
    cfg_state_e s;
    s = ST_DEV;
    case (sel)
      SEL_DEV: s = ST_DEV;
      SEL_AH:  s = ST_AH;
      SEL_AL:  s = ST_AL;
      default: s = ST_DAT;
    endcase
    return s;
  endfunction

  // Pause length in clk cycles, clamped to the 32-bit counter range.
  function automatic logic [31:0] delay_cycles(input logic [7:0] ms,
                                               input logic [31:0] clk_per_ms);
    logic [63:0] p;
    p = 64'(ms) * 64'(clk_per_ms);
    return (p[63:32] != 32'd0) ? 32'hFFFF_FFFF : p[31:0];
  endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Down-counting pause timer. Expires while the count is 1 or 0, so a
// load of N holds the sequencer for N cycles and a load of 0 for one.
module cfg_delay_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_count,
  input  logic        i_en,
  output logic        o_expire
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_count;
    end else if (i_en && (r_count != 32'd0)) begin
      r_count <= r_count - 32'd1;
    end
  end

  assign o_expire = (r_count <= 32'd1);

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Walks a register table and writes each entry to the camera sensor over an
// I2C byte engine, with pause entries, per-entry NACK retries and error report.
module cam_cfg_sequencer
  import cam_cfg_pkg::*;
#(
  parameter int         NUM_ENTRIES = 64,
  parameter logic [6:0] DEV_ADDR    = 7'h36,
  parameter int         CLK_PER_MS  = 50000,
  parameter int         MAX_RETRY   = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [$clog2(NUM_ENTRIES)-1:0] err_index,
  output logic [$clog2(NUM_ENTRIES)-1:0] tbl_addr,
  input  logic [23:0]                    tbl_data,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [7:0]                     cmd_byte,
  output logic                           cmd_start,
  output logic                           cmd_stop,
  input  logic                           rsp_valid,
  input  logic                           rsp_ack,
  output logic [3:0]                     dbg_state
);

  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [IW-1:0] LAST_INDEX = IW'(NUM_ENTRIES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  // cmd_valid/ready: a command is transferred on a cycle where both are high;
  // the command fields are held unchanged from cmd_valid rising until then.
  cfg_state_e    r_state;
  logic [IW-1:0] r_index;
  logic [RW-1:0] r_retry;
  logic [1:0]    r_byte_sel;
  logic [15:0]   r_reg_addr;
  logic [7:0]    r_value;
  logic          r_busy;
  logic          r_done;
  logic          r_error;
  logic [IW-1:0] r_err_index;
  logic [IW-1:0] r_tbl_addr;
  logic          r_cmd_valid;
  logic [7:0]    r_cmd_byte;
  logic          r_cmd_start;
  logic          r_cmd_stop;

  logic [15:0]   w_entry_addr;
  logic [7:0]    w_entry_val;
  logic          w_is_delay;
  logic          w_timer_load;
  logic [31:0]   w_timer_count;
  logic          w_timer_en;
  logic          w_expire;
  logic [1:0]    w_sel_next;
  logic [IW-1:0] w_index_next;

  assign w_entry_addr  = tbl_data[ENTRY_ADDR_HI:ENTRY_ADDR_LO];
  assign w_entry_val   = tbl_data[ENTRY_VAL_HI:ENTRY_VAL_LO];
  assign w_is_delay    = (w_entry_addr == DELAY_MARKER);
  assign w_timer_load  = (r_state == ST_LATCH) && w_is_delay;
  assign w_timer_count = delay_cycles(w_entry_val, 32'(CLK_PER_MS));
  assign w_timer_en    = (r_state == ST_DELAY);
  assign w_sel_next    = r_byte_sel + 2'd1;
  assign w_index_next  = r_index + IW'(1);

  cfg_delay_timer u_delay_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_timer_load),
    .i_count  (w_timer_count),
    .i_en     (w_timer_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_retry     <= '0;
      r_byte_sel  <= SEL_DEV;
      r_reg_addr  <= '0;
      r_value     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_index <= '0;
      r_tbl_addr  <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_byte  <= '0;
      r_cmd_start <= 1'b0;
      r_cmd_stop  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            r_index    <= '0;
            r_tbl_addr <= '0;
            r_retry    <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_LATCH;
        ST_LATCH: begin
          r_reg_addr <= w_entry_addr;
          r_value    <= w_entry_val;
          if (w_is_delay) begin
            r_state <= ST_DELAY;
          end else begin
            r_byte_sel <= SEL_DEV;
            {r_cmd_start, r_cmd_stop, r_cmd_byte} <=
              cfg_cmd(SEL_DEV, DEV_ADDR, w_entry_addr, w_entry_val);
            r_cmd_valid <= 1'b1;
            r_state     <= ST_DEV;
          end
        end
        ST_DEV, ST_AH, ST_AL, ST_DAT: begin
          if (r_cmd_valid && cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rsp_valid) begin
            if (rsp_ack) begin
              if (r_byte_sel == SEL_DAT) begin
                r_state <= ST_NEXT;
              end else begin
                r_byte_sel <= w_sel_next;
                {r_cmd_start, r_cmd_stop, r_cmd_byte} <=
                  cfg_cmd(w_sel_next, DEV_ADDR, r_reg_addr, r_value);
                r_cmd_valid <= 1'b1;
                r_state     <= byte_state(w_sel_next);
              end
            end else if (r_retry < RETRY_LIMIT) begin
              // The engine already sent STOP after the NACK; restart the entry.
              r_retry    <= r_retry + RW'(1);
              r_byte_sel <= SEL_DEV;
              {r_cmd_start, r_cmd_stop, r_cmd_byte} <=
                cfg_cmd(SEL_DEV, DEV_ADDR, r_reg_addr, r_value);
              r_cmd_valid <= 1'b1;
              r_state     <= ST_DEV;
            end else begin
              r_err_index <= r_index;
              r_error     <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_ERROR;
            end
          end
        end
        ST_DELAY: begin
          if (w_expire) r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          r_retry <= '0;
          if (r_index == LAST_INDEX) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_index    <= w_index_next;
            r_tbl_addr <= w_index_next;
            r_state    <= ST_FETCH;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign err_index = r_err_index;
  assign tbl_addr  = r_tbl_addr;
  assign cmd_valid = r_cmd_valid;
  assign cmd_byte  = r_cmd_byte;
  assign cmd_start = r_cmd_start;
  assign cmd_stop  = r_cmd_stop;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Bench for cam_cfg_sequencer: table vectors, directed corner sequences and
// randomized tables checked against a behavioural model of the table walk.
module tb_cam_cfg_sequencer;
  import cam_cfg_pkg::*;

  localparam int         NUM_ENTRIES = 2;
  localparam int         CLK_PER_MS  = 10;
  localparam int         MAX_RETRY   = 3;
  localparam logic [6:0] DEV_ADDR    = 7'h36;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, error;
  logic [0:0]  err_index, tbl_addr;
  logic [23:0] tbl_data;
  logic        cmd_valid, cmd_ready, cmd_start, cmd_stop;
  logic [7:0]  cmd_byte;
  logic        rsp_valid, rsp_ack;
  logic [3:0]  dbg_state;

  logic [23:0] rom [NUM_ENTRIES];

  int checks = 0;
  int failures = 0;

  // engine model state
  bit          eng_rdy_mode = 1'b1;
  int          stall_left = 0;
  bit          inj_rsp = 1'b0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  bit          pend_ack = 1'b1;
  bit          eng_plan[$];
  logic [9:0]  act_q[$];
  int          n_accept = 0;
  logic        p_valid = 1'b0, p_ready = 1'b0, p_reset = 1'b0;
  logic [9:0]  p_cmd = '0;

  // reference model results
  bit          m_plan[$];
  logic [9:0]  exp_q[$];
  bit          m_done, m_err;
  int          m_eidx;

  typedef struct {
    logic [23:0] e0;
    logic [23:0] e1;
    logic [31:0] nmask;
    logic        exp_done;
    logic        exp_err;
    int          exp_eidx;
    int          exp_ncmd;
    int          exp_ndev;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  always_ff @(posedge clk) tbl_data <= rom[tbl_addr];

  cam_cfg_sequencer #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .DEV_ADDR    (DEV_ADDR),
    .CLK_PER_MS  (CLK_PER_MS),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_index (err_index),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_byte  (cmd_byte),
    .cmd_start (cmd_start),
    .cmd_stop  (cmd_stop),
    .rsp_valid (rsp_valid),
    .rsp_ack   (rsp_ack),
    .dbg_state (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // I2C byte engine: accepts commands, answers each with one rsp pulse.
  initial begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_ack   = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      rsp_ack   = 1'b0;
      if (p_valid && p_ready) begin
        act_q.push_back(p_cmd);
        n_accept++;
        chk("single_outstanding", 32'(pend), 32'd0);
        chk("valid_drops_after_accept", 32'(cmd_valid), 32'd0);
        pend     = 1'b1;
        pend_cnt = $urandom_range(1, 3);
        pend_ack = (eng_plan.size() > 0) ? eng_plan.pop_front() : 1'b1;
      end else if (p_valid && !p_reset) begin
        chk("hold_valid", 32'(cmd_valid), 32'd1);
        chk("hold_cmd", 32'({cmd_start, cmd_stop, cmd_byte}), 32'(p_cmd));
      end
      if (inj_rsp) begin
        rsp_valid = 1'b1;
        rsp_ack   = 1'b1;
      end else if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_ack   = pend_ack;
          pend      = 1'b0;
        end
      end
      if (stall_left > 0 && cmd_valid) begin
        cmd_ready = 1'b0;
        stall_left--;
      end else begin
        cmd_ready = eng_rdy_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      p_valid = cmd_valid;
      p_ready = cmd_ready;
      p_cmd   = {cmd_start, cmd_stop, cmd_byte};
      p_reset = reset;
    end
  end

  // Expected command stream and outcome of one table walk.
  task automatic model_expect();
    int retries;
    bit ok, ack;
    logic [9:0] bytes [4];
    exp_q.delete();
    m_err  = 1'b0;
    m_eidx = 0;
    for (int e = 0; e < NUM_ENTRIES && !m_err; e++) begin
      if (rom[e][23:8] == 16'hFFFF) continue;
      bytes[0] = {2'b10, DEV_ADDR, 1'b0};
      bytes[1] = {2'b00, rom[e][23:16]};
      bytes[2] = {2'b00, rom[e][15:8]};
      bytes[3] = {2'b01, rom[e][7:0]};
      retries = 0;
      ok = 1'b0;
      while (!ok && !m_err) begin
        ok = 1'b1;
        for (int b = 0; b < 4 && ok; b++) begin
          exp_q.push_back(bytes[b]);
          ack = (m_plan.size() > 0) ? m_plan.pop_front() : 1'b1;
          if (!ack) ok = 1'b0;
        end
        if (!ok) begin
          if (retries < MAX_RETRY) retries++;
          else begin
            m_err  = 1'b1;
            m_eidx = e;
          end
        end
      end
    end
    m_done = !m_err;
  endtask

  task automatic load_run(input logic [23:0] e0, input logic [23:0] e1, input logic [31:0] nmask);
    rom[0] = e0;
    rom[1] = e1;
    eng_plan.delete();
    m_plan.delete();
    for (int i = 0; i < 32; i++) begin
      eng_plan.push_back(!nmask[i]);
      m_plan.push_back(!nmask[i]);
    end
    model_expect();
    act_q.delete();
    n_accept = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || error) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("run_ends_in_budget", 32'(done || error), 32'd1);
  endtask

  task automatic wait_engine_idle();
    int n;
    n = 0;
    while (pend && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    chk("engine_idle", 32'(pend), 32'd0);
  endtask

  task automatic check_result(input string tag);
    int n;
    chk($sformatf("%s_busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s_done", tag), 32'(done), 32'(m_done));
    chk($sformatf("%s_error", tag), 32'(error), 32'(m_err));
    if (m_err) chk($sformatf("%s_err_index", tag), 32'(err_index), 32'(m_eidx));
    chk($sformatf("%s_ncmd", tag), 32'(act_q.size()), 32'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_cmd%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [9:0] v0_bytes [8];
    logic [9:0] held;
    int n, bad, ndev;

    vecs[0] = '{24'h300802, 24'h010001, 32'h0000_0000, 1'b1, 1'b0, 0, 8, 2};
    vecs[1] = '{24'hFFFF05, 24'h010001, 32'h0000_0000, 1'b1, 1'b0, 0, 4, 1};
    vecs[2] = '{24'h300802, 24'h010001, 32'h0000_000A, 1'b1, 1'b0, 0, 12, 4};
    vecs[3] = '{24'h300802, 24'h010001, 32'h0000_00F0, 1'b0, 1'b1, 1, 8, 5};
    vecs[4] = '{24'h300802, 24'h010001, 32'h0000_0888, 1'b1, 1'b0, 0, 20, 5};
    vecs[5] = '{24'h300802, 24'h010001, 32'h0000_000F, 1'b0, 1'b1, 0, 4, 4};
    vecs[6] = '{24'hFFFF00, 24'hFFFF01, 32'h0000_0000, 1'b1, 1'b0, 0, 0, 0};
    v0_bytes = '{10'h26C, 10'h030, 10'h008, 10'h102, 10'h26C, 10'h001, 10'h000, 10'h101};

    // clock/reset
    reset = 1'b1;
    start = 1'b0;
    rom[0] = '0;
    rom[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero",
        32'({busy, done, error, err_index, tbl_addr, cmd_valid, cmd_start, cmd_stop, cmd_byte}), 32'd0);
    chk("reset_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;

    // stray response in IDLE, and no command before start
    inj_rsp = 1'b1;
    @(posedge clk); #1;
    inj_rsp = 1'b0;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (cmd_valid || busy) bad++;
    end
    chk("idle_quiet_without_start", 32'(bad), 32'd0);

    // table vectors
    eng_rdy_mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      load_run(vecs[i].e0, vecs[i].e1, vecs[i].nmask);
      do_start();
      wait_end();
      wait_engine_idle();
      check_result($sformatf("vec%0d", i));
      ndev = 0;
      foreach (act_q[k]) if (act_q[k][9]) ndev++;
      chk($sformatf("vec%0d_tbl_done", i), 32'(done), 32'(vecs[i].exp_done));
      chk($sformatf("vec%0d_tbl_error", i), 32'(error), 32'(vecs[i].exp_err));
      if (vecs[i].exp_err)
        chk($sformatf("vec%0d_tbl_err_index", i), 32'(err_index), 32'(vecs[i].exp_eidx));
      chk($sformatf("vec%0d_tbl_ncmd", i), 32'(act_q.size()), 32'(vecs[i].exp_ncmd));
      chk($sformatf("vec%0d_tbl_ndev", i), 32'(ndev), 32'(vecs[i].exp_ndev));
      if (i == 0 && act_q.size() == 8)
        for (int k = 0; k < 8; k++) chk($sformatf("vec0_byte%0d", k), 32'(act_q[k]), 32'(v0_bytes[k]));
    end

    // delay entry: 5 ms of 10 cycles, then entry 1 is fetched
    load_run(24'hFFFF05, 24'h010001, 32'h0);
    do_start();
    n = 1;
    bad = 0;
    while (tbl_addr !== 1'b1 && n < 300) begin
      if (cmd_valid) bad++;
      @(posedge clk); #1;
      n++;
    end
    chk("delay_fetch_latency", 32'(n), 32'(5 * CLK_PER_MS + 4));
    chk("delay_no_cmd", 32'(bad), 32'd0);
    wait_end();
    wait_engine_idle();
    check_result("delay");

    // backpressure for 7 cycles with an ignored start while busy
    load_run(24'h300802, 24'h010001, 32'h0);
    stall_left = 7;
    do_start();
    n = 0;
    while (!cmd_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_cmd_presented", 32'(cmd_valid), 32'd1);
    held = {cmd_start, cmd_stop, cmd_byte};
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("bp_hold%0d", k), 32'({cmd_valid, cmd_start, cmd_stop, cmd_byte}), 32'({1'b1, held}));
      chk($sformatf("bp_no_accept%0d", k), 32'(n_accept), 32'd0);
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_one_accept", 32'(n_accept), 32'd1);
    wait_end();
    wait_engine_idle();
    check_result("bp");

    // reset while the AL byte is presented, then a clean replay
    eng_rdy_mode = 1'b0;
    load_run(24'h300802, 24'h010001, 32'h0);
    do_start();
    n = 0;
    while (!(cmd_valid && act_q.size() == 2) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_al_presented", 32'({cmd_valid, cmd_byte}), 32'({1'b1, 8'h08}));
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_outputs_zero",
        32'({busy, done, error, err_index, tbl_addr, cmd_valid, cmd_start, cmd_stop, cmd_byte}), 32'd0);
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (cmd_valid || busy) bad++;
    end
    chk("rst_quiet_until_start", 32'(bad), 32'd0);
    wait_engine_idle();
    load_run(24'h300802, 24'h010001, 32'h0);
    do_start();
    wait_end();
    wait_engine_idle();
    check_result("rst_replay");

    // randomized tables, responses and ready
    for (int r = 0; r < 30; r++) begin
      logic [23:0] ent [2];
      for (int e = 0; e < 2; e++) begin
        if ($urandom_range(0, 3) == 0)
          ent[e] = {16'hFFFF, 8'($urandom_range(0, 3))};
        else
          ent[e] = {16'($urandom_range(0, 16'hFFFE)), 8'($urandom)};
      end
      load_run(ent[0], ent[1], $urandom & $urandom);
      do_start();
      wait_end();
      wait_engine_idle();
      check_result($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    failures++;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
